sweep_controller: RTL and testbench
===================================

# sweep_controller

Frequency-sweep sequencer for the function generator's regulation loop. It drives the target period into the frequency regulator, pulses the regulator's reset so the divider reloads for each new point, and watches the regulator's measured high-duration on every falling edge of `psi`. It steps from a start period to a stop period, waits for lock at each point and dwells there, then advances. Timeouts are reported as errors.

## Interface
- `TOL`, 2: max allowed |clkDuration − setPeriod| for an in-tolerance edge.
- `LOCK_COUNT`, 4: consecutive in-tolerance falling edges required to declare lock (≥1).
- `DWELL`, 16: falling edges to hold each locked point (≥1).
- `TIMEOUT`, 64: falling edges allowed in SETTLE before error (> `LOCK_COUNT`).

- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin sweep; sampled only in IDLE, DONE, ERROR.
- `abort` in 1: return to IDLE from any state; has priority over `start`.
- `startPeriod` in 8: first target period.
- `stopPeriod` in 8: last target period.
- `stepSize` in 8: period increment per point; 0 is treated as 1.
- `psi` in 1: regulated waveform, fed back from the generator (synchronous to `clk`).
- `clkDuration` in 8: regulator's measured duration ×2.
- `setPeriod` out 8: target period to regulator (registered).
- `regRst` out 1: active-high one-cycle regulator reset pulse (registered).
- `busy` out 1: high in LOAD, SETTLE, DWELL, STEP.
- `locked` out 1: high in DWELL only.
- `done` out 1: high in DONE.
- `error` out 1: high in ERROR.

## Operation
- Reset values: `setPeriod`=0, `regRst`=0, `busy`=0, `locked`=0, `done`=0, `error`=0. FSM=IDLE, all counters 0.
- Edge detect: `psi` registered into `psiQ`. A falling edge is `psiQ`=1, `psi`=0. `clkDuration` is sampled in that same cycle.
- In tolerance: unsigned absolute difference of `clkDuration` and `setPeriod` ≤ `TOL`. Compute with a 9-bit difference so there is no wrap.
- Direction: latched at start. Up if `stopPeriod` ≥ `startPeriod`, else down. `startPeriod`, `stopPeriod` and the effective step are latched at start. Later input changes are ignored until the next start.
- States:
  - IDLE: outputs idle. `start` → LOAD with `setPeriod`←`startPeriod`.
  - LOAD (1 cycle): `regRst`=1 this cycle. Clear lock count, timeout count and discard flag. → SETTLE.
  - SETTLE:
    - The first falling edge after LOAD is discarded (partial pulse).
    - Each later edge increments the timeout count.
    - An in-tolerance edge increments the lock count; an out-of-tolerance edge clears it.
    - Lock count reaching `LOCK_COUNT` → DWELL, with the dwell count cleared.
    - Otherwise, timeout count reaching `TIMEOUT` → ERROR.
    - If both occur on the same edge, lock wins.
  - DWELL:
    - Each in-tolerance edge increments the dwell count.
    - An out-of-tolerance edge → SETTLE, with lock and timeout counts cleared and no discard.
    - Dwell count reaching `DWELL`: if `setPeriod`==stop → DONE, else → STEP.
  - STEP (1 cycle): next = `setPeriod` ± step, computed at 9 bits. If next passes stop (or over/underflows 8 bits), clamp to stop. → LOAD.
  - DONE / ERROR: held until `start` (→ LOAD, restarting the sweep) or `abort` (→ IDLE).
- `abort` in any state → IDLE next cycle. `setPeriod` retains its value and `regRst` is not pulsed.
- `start` while busy is ignored.

## Timing
- `start` sampled at edge N → LOAD at N+1, `regRst`=1 during cycle N+1, SETTLE at N+2.
- A falling edge on `psi` seen at edge M is acted on at M (registered output changes visible after M).
- Lock at the `LOCK_COUNT`-th valid edge: `locked`=1 the following cycle.
- STEP→LOAD adds 2 cycles between dwell end and the new `regRst` pulse.
- Single-point sweep (`startPeriod`==`stopPeriod`): LOAD→SETTLE→DWELL→DONE with no STEP.
- `rst` low mid-sweep: all outputs reset immediately (asynchronous); resume only on a new `start` after release.

## Test plan
- Up sweep: start=20, stop=40, step=10, regulator model returning exact duration → `setPeriod` 20,30,40. Three `regRst` pulses, `locked` per point for 16 edges, then `done`=1.
- Down sweep with clamp: start=50, stop=12, step=20 → `setPeriod` 50,30,12, then `done`.
- Timeout: `clkDuration` fixed at `setPeriod`+5 → `error`=1 after discard edge + 64 edges; `busy`=0. `start` restarts from LOAD.
- Lock loss: a single out-of-tolerance edge during DWELL → `locked` drops, re-locks after 4 good edges, and the dwell count restarts from 0.
- Priority/step edge cases: `abort`+`start` in the same cycle → IDLE. `stepSize`=0 with start=100, stop=102 → points 100,101,102. start=250, stop=255, step=10 → 250,255 (no wrap).
- Async reset asserted in DWELL → all outputs 0 without a clock edge; FSM in IDLE after release.

Source files
------------

// File: rtl/sweep_controller.sv
// Frequency-sweep sequencer: steps the regulator target from a start to a stop period,
// waiting for lock and dwelling at each point; reports timeouts as an error.
module sweep_controller #(
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int DWELL      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] startPeriod,
    input  logic [7:0] stopPeriod,
    input  logic [7:0] stepSize,
    input  logic       psi,
    input  logic [7:0] clkDuration,
    output logic [7:0] setPeriod,
    output logic       regRst,
    output logic       busy,
    output logic       locked,
    output logic       done,
    output logic       error,
    output logic [2:0] state_dbg
);

    localparam int CW = 16;
    localparam logic [CW-1:0] LOCK_MAX  = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL);
    localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_STEP   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      set_period_q, set_period_d;
    logic [7:0]      stop_q, stop_d;
    logic [7:0]      step_q, step_d;
    logic            up_q, up_d;
    logic            reg_rst_q, reg_rst_d;
    logic            psi_q;
    logic            discard_q, discard_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CW-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic            fall;
    logic            in_tol;
    logic [8:0]      diff;
    logic [8:0]      sum9;
    logic [8:0]      dif9;
    logic [7:0]      step_next;
    logic [CW-1:0]   lock_nxt;
    logic [CW-1:0]   tmo_nxt;
    logic [CW-1:0]   dwell_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            set_period_q <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            up_q         <= 1'b0;
            reg_rst_q    <= 1'b0;
            psi_q        <= 1'b0;
            discard_q    <= 1'b0;
            lock_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            set_period_q <= set_period_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            up_q         <= up_d;
            reg_rst_q    <= reg_rst_d;
            psi_q        <= psi;
            discard_q    <= discard_d;
            lock_cnt_q   <= lock_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        set_period_d = set_period_q;
        stop_d       = stop_q;
        step_d       = step_q;
        up_d         = up_q;
        reg_rst_d    = 1'b0;
        discard_d    = discard_q;
        lock_cnt_d   = lock_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;

        fall = psi_q & ~psi;
        // 9-bit magnitude so the difference cannot wrap
        diff = (clkDuration >= set_period_q) ? ({1'b0, clkDuration} - {1'b0, set_period_q})
                                             : ({1'b0, set_period_q} - {1'b0, clkDuration});
        in_tol    = (diff <= 9'(TOL));
        lock_nxt  = in_tol ? (lock_cnt_q + CW'(1)) : '0;
        tmo_nxt   = tmo_cnt_q + CW'(1);
        dwell_nxt = dwell_cnt_q + CW'(1);

        sum9 = {1'b0, set_period_q} + {1'b0, step_q};
        dif9 = {1'b0, set_period_q} - {1'b0, step_q};
        if (up_q) begin
            step_next = (sum9 > {1'b0, stop_q}) ? stop_q : sum9[7:0];
        end else begin
            step_next = (dif9[8] || (dif9[7:0] < stop_q)) ? stop_q : dif9[7:0];
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_d      = S_LOAD;
                        set_period_d = startPeriod;
                        stop_d       = stopPeriod;
                        step_d       = (stepSize == 8'd0) ? 8'd1 : stepSize;
                        up_d         = (stopPeriod >= startPeriod);
                        reg_rst_d    = 1'b1;
                    end
                end
                S_LOAD: begin
                    lock_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    discard_d  = 1'b0;
                    state_d    = S_SETTLE;
                end
                S_SETTLE: begin
                    if (fall) begin
                        if (!discard_q) begin
                            // first edge after the regulator reset is a partial pulse
                            discard_d = 1'b1;
                        end else begin
                            tmo_cnt_d  = tmo_nxt;
                            lock_cnt_d = lock_nxt;
                            if (lock_nxt == LOCK_MAX) begin
                                state_d     = S_DWELL;
                                dwell_cnt_d = '0;
                            end else if (tmo_nxt == TMO_MAX) begin
                                state_d = S_ERROR;
                            end
                        end
                    end
                end
                S_DWELL: begin
                    if (fall) begin
                        if (in_tol) begin
                            dwell_cnt_d = dwell_nxt;
                            if (dwell_nxt == DWELL_MAX) begin
                                state_d = (set_period_q == stop_q) ? S_DONE : S_STEP;
                            end
                        end else begin
                            state_d    = S_SETTLE;
                            lock_cnt_d = '0;
                            tmo_cnt_d  = '0;
                            discard_d  = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    set_period_d = step_next;
                    state_d      = S_LOAD;
                    reg_rst_d    = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign setPeriod = set_period_q;
    assign regRst    = reg_rst_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_SETTLE) ||
                       (state_q == S_DWELL) || (state_q == S_STEP);
    assign locked    = (state_q == S_DWELL);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: a square-wave regulator model on psi, a period scoreboard
// checked on every regRst pulse, and a queue of expected locked run lengths.
module tb_sweep_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] start_period;
    logic [7:0] stop_period;
    logic [7:0] step_size;
    logic       psi = 1'b0;
    logic [7:0] clk_duration = 8'd0;
    logic [7:0] set_period;
    logic       reg_rst;
    logic       busy;
    logic       locked;
    logic       done;
    logic       error;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         run_q[$];

    int         ph = 0;
    int         bad_cnt = 0;
    logic [7:0] dur_ofs = 8'd0;

    int   fall_cnt = 0;
    int   base_cnt = 0;
    int   run_len = 0;
    logic psi_prev = 1'b0;
    logic regrst_prev = 1'b0;
    logic since_load = 1'b0;
    logic lock_prev = 1'b0;

    sweep_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .startPeriod (start_period),
        .stopPeriod  (stop_period),
        .stepSize    (step_size),
        .psi         (psi),
        .clkDuration (clk_duration),
        .setPeriod   (set_period),
        .regRst      (reg_rst),
        .busy        (busy),
        .locked      (locked),
        .done        (done),
        .error       (error),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Regulator model: psi falls every 6 cycles; duration tracks the target plus an offset.
    always @(negedge clk) begin
        ph = ph + 1;
        if (ph == 3) begin
            ph  = 0;
            psi = ~psi;
        end
        if (ph == 0 && psi == 1'b0 && bad_cnt > 0) begin
            clk_duration = set_period + 8'd5;
            bad_cnt      = bad_cnt - 1;
        end else begin
            clk_duration = set_period + dur_ofs;
        end
    end

    // Scoreboard monitor
    always @(posedge clk) begin
        #1;
        if (psi_prev && !psi) fall_cnt++;
        psi_prev = psi;
        if (regrst_prev) begin
            base_cnt   = fall_cnt;
            since_load = 1'b1;
        end
        regrst_prev = reg_rst;
        if (reg_rst) begin
            chk("regrst_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("period", set_period, exp_q.pop_front());
        end
        if (locked && !lock_prev) begin
            if (since_load) chk("lock_edges", fall_cnt - base_cnt, 5);
            since_load = 1'b0;
            run_len    = 0;
        end
        if (locked) run_len++;
        if (!locked && lock_prev && run_q.size() > 0) chk("dwell_len", run_len, run_q.pop_front());
        lock_prev = locked;
    end

    task automatic go(input logic [7:0] sp, input logic [7:0] ep, input logic [7:0] st);
        @(negedge clk);
        start_period = sp;
        stop_period  = ep;
        step_size    = st;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // sel: 0 done, 1 error, 2 locked, 3 not locked
    task automatic wait_for(input string tag, input int sel, input int budget);
        int   n = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(posedge clk);
            #2;
            n++;
            case (sel)
                0:       hit = done;
                1:       hit = error;
                2:       hit = locked;
                default: hit = !locked;
            endcase
        end
        chk({tag, "_seen"}, hit, 1);
    endtask

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        start_period = 8'd0; stop_period = 8'd0; step_size = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_period", set_period, 0);
        chk("rst_regrst", reg_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        rst = 1'b1;

        // up sweep
        exp_q.push_back(8'd20); exp_q.push_back(8'd30); exp_q.push_back(8'd40);
        repeat (3) run_q.push_back(96);
        go(8'd20, 8'd40, 8'd10);
        wait_for("up_done", 0, 3000);
        chk("up_end_period", set_period, 40);
        chk("up_busy", busy, 0);
        chk("up_pending", exp_q.size(), 0);

        // down sweep with clamp
        exp_q.push_back(8'd50); exp_q.push_back(8'd30); exp_q.push_back(8'd12);
        repeat (3) run_q.push_back(96);
        go(8'd50, 8'd12, 8'd20);
        wait_for("down_done", 0, 3000);
        chk("down_end_period", set_period, 12);
        chk("down_pending", exp_q.size(), 0);

        // single point with a lock loss on the 5th dwell edge
        exp_q.push_back(8'd70);
        run_q.push_back(30); run_q.push_back(96);
        go(8'd70, 8'd70, 8'd5);
        wait_for("ll_lock", 2, 500);
        repeat (24) @(posedge clk);
        bad_cnt = 1;
        wait_for("ll_drop", 3, 100);
        chk("ll_busy", busy, 1);
        n = 0;
        while (!locked && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("relock_gap", n, 24);
        wait_for("ll_done", 0, 500);
        chk("ll_run_pending", run_q.size(), 0);

        // abort and start together from DONE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_state", state_dbg, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_period_kept", set_period, 70);
        repeat (3) @(posedge clk);
        #2;
        chk("abort_stays_idle", state_dbg, 0);

        // zero step treated as one
        exp_q.push_back(8'd100); exp_q.push_back(8'd101); exp_q.push_back(8'd102);
        go(8'd100, 8'd102, 8'd0);
        wait_for("step0_done", 0, 3000);
        chk("step0_pending", exp_q.size(), 0);

        // clamp at the top of the range, no wrap
        exp_q.push_back(8'd250); exp_q.push_back(8'd255);
        go(8'd250, 8'd255, 8'd10);
        wait_for("top_done", 0, 3000);
        chk("top_end_period", set_period, 255);
        chk("top_pending", exp_q.size(), 0);

        // timeout, restart from ERROR, then abort mid-settle
        dur_ofs = 8'd5;
        exp_q.push_back(8'd30);
        go(8'd30, 8'd60, 8'd10);
        wait_for("tmo_error", 1, 1000);
        chk("tmo_edges", fall_cnt - base_cnt, 65);
        chk("tmo_busy", busy, 0);
        chk("tmo_locked", locked, 0);
        exp_q.push_back(8'd30);
        go(8'd30, 8'd60, 8'd10);
        repeat (4) @(posedge clk);
        #2;
        chk("restart_busy", busy, 1);
        chk("restart_error", error, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_settle_state", state_dbg, 0);
        chk("abort_settle_busy", busy, 0);
        chk("abort_settle_period", set_period, 30);
        dur_ofs = 8'd0;

        // asynchronous reset while dwelling
        exp_q.push_back(8'd80);
        go(8'd80, 8'd90, 8'd10);
        wait_for("ar_lock", 2, 500);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_period", set_period, 0);
        chk("ar_locked", locked, 0);
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_error", error, 0);
        chk("ar_regrst", reg_rst, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("ar_idle_state", state_dbg, 0);
        chk("ar_idle_busy", busy, 0);

        chk("final_exp_q", exp_q.size(), 0);
        chk("final_run_q", run_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
